// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state encoding,
// grant identifiers and the round-robin winner selection.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {G_FETCH, G_DATA} arb_grant_t;

  // A lone requester always wins; on a tie the port not served last goes first.
  function automatic arb_grant_t pick_winner(input logic ireq,
                                             input logic dreq,
                                             input arb_grant_t last);
    arb_grant_t win;
    if (ireq && dreq) begin
      if (last == G_FETCH) win = G_DATA;
      else                 win = G_FETCH;
    end else if (dreq) begin
      win = G_DATA;
    end else begin
      win = G_FETCH;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serialises MIPS fetch and data accesses onto one single-ported unified memory,
// acknowledging the winner with a one-cycle pulse and driving pipeline stalls.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iadr,
  output logic [DW-1:0] irdata,
  output logic          iack,
  output logic          istall,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] dadr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dack,
  output logic          dstall,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] madr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata
);

  localparam int CW = $clog2(LAT + 1);

  arb_state_t     state_q, state_d;
  arb_grant_t     grant_q, grant_d;
  arb_grant_t     last_q, last_d;
  arb_grant_t     winner;
  logic [AW-1:0]  adr_q, adr_d;
  logic           we_q, we_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  assign winner = pick_winner(ireq, dreq, last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ireq || dreq) state_d = ISSUE;
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= G_FETCH;
      last_q  <= G_FETCH;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Requester inputs are only looked at in IDLE; afterwards the captured copy drives memory.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ireq || dreq) begin
          grant_d = winner;
          if (winner == G_DATA) begin
            adr_d   = dadr;
            we_d    = dwe;
            wdata_d = dwdata;
          end else begin
            adr_d = iadr;
            we_d  = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (!we_q) cnt_d = CW'(LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) rdata_d = mrdata;
      end
      DONE: begin
        last_d = grant_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Stalls drop in the ack cycle so the pipeline advances on that same edge.
  always_comb begin
    mreq   = (state_q == ISSUE);
    mwe    = (state_q == ISSUE) && we_q;
    madr   = adr_q;
    mwdata = wdata_q;
    iack   = (state_q == DONE) && (grant_q == G_FETCH);
    dack   = (state_q == DONE) && (grant_q == G_DATA);
    irdata = rdata_q;
    drdata = rdata_q;
    istall = ireq && !iack;
    dstall = dreq && !dack;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, multi-cycle corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [31:0] iadr = '0, dadr = '0, dwdata = '0;
  logic [31:0] irdata, drdata, madr, mwdata, mrdata;
  logic        iack, istall, dack, dstall, mreq, mwe;

  logic        ireq_a = 1'b0, iack_a, istall_a, dack_a, dstall_a, mreq_a, mwe_a;
  logic [31:0] irdata_a, drdata_a, madr_a, mwdata_a;
  logic        ireq_b = 1'b0, iack_b, istall_b, dack_b, dstall_b, mreq_b, mwe_b;
  logic [31:0] irdata_b, drdata_b, madr_b, mwdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iadr(iadr), .irdata(irdata), .iack(iack), .istall(istall),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata), .drdata(drdata),
    .dack(dack), .dstall(dstall),
    .mreq(mreq), .mwe(mwe), .madr(madr), .mwdata(mwdata), .mrdata(mrdata)
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .ireq(ireq_a), .iadr(32'h0), .irdata(irdata_a), .iack(iack_a), .istall(istall_a),
    .dreq(1'b0), .dwe(1'b0), .dadr(32'h0), .dwdata(32'h0), .drdata(drdata_a),
    .dack(dack_a), .dstall(dstall_a),
    .mreq(mreq_a), .mwe(mwe_a), .madr(madr_a), .mwdata(mwdata_a), .mrdata(32'h1111_0001)
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(4)) dut_lat4 (
    .clk(clk), .reset(reset),
    .ireq(ireq_b), .iadr(32'h0), .irdata(irdata_b), .iack(iack_b), .istall(istall_b),
    .dreq(1'b0), .dwe(1'b0), .dadr(32'h0), .dwdata(32'h0), .drdata(drdata_b),
    .dack(dack_b), .dstall(dstall_b),
    .mreq(mreq_b), .mwe(mwe_b), .madr(madr_b), .mwdata(mwdata_b), .mrdata(32'h4444_0004)
  );

  // Unified memory: read data is presented only in the cycle exactly LAT after mreq.
  logic [31:0] mem    [0:255];
  logic [31:0] pipe_d [0:LAT-1];
  logic        pipe_v [0:LAT-1];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i) * 32'h11;
    mem[0] <= 32'h2002_0005;
    for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
  end

  always @(posedge clk) begin
    if (mreq && mwe) mem[madr[9:2]] <= mwdata;
    pipe_v[0] <= mreq && !mwe;
    pipe_d[0] <= mem[madr[9:2]];
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mrdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0_BAD0;

  // Requests must stay up until acknowledged.
  logic i_pend = 1'b0, d_pend = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      i_pend <= 1'b0;
      d_pend <= 1'b0;
    end else begin
      if (i_pend && !ireq) begin
        errors++;
        $display("[TB] FAIL ireq_protocol actual=0 required=1");
      end
      if (d_pend && !dreq) begin
        errors++;
        $display("[TB] FAIL dreq_protocol actual=0 required=1");
      end
      i_pend <= ireq && !iack;
      d_pend <= dreq && !dack;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic applyStimulus(input vec_t v);
    ireq   = !v.is_data;
    dreq   = v.is_data;
    dwe    = v.we;
    iadr   = v.adr;
    dadr   = v.adr;
    dwdata = v.wdata;
  endtask

  // Transaction-level reference model state
  logic [31:0] shadow [0:255];
  bit          m_busy, m_port, m_we, m_last;
  logic [31:0] m_adr, m_wd, m_rd;
  int          m_start, m_ack_at;
  bit          seen_i, seen_d;

  function automatic logic [31:0] randAdr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin
    int got, gota, gotb;
    bit exp_i, exp_d, exp_m;

    vecs[0] = '{1'b1, 1'b1, 32'h54, 32'h7,         2, 32'h1000_0022};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  32'h0,         4, 32'h2002_0005};
    vecs[2] = '{1'b1, 1'b0, 32'h54, 32'h0,         4, 32'h0000_0007};
    vecs[3] = '{1'b1, 1'b1, 32'h58, 32'hCAFE_F00D, 2, 32'h0000_0007};
    vecs[4] = '{1'b0, 1'b0, 32'h58, 32'h0,         4, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h8,  32'h0,         4, 32'h1000_0022};

    // Reset state, with both requests already pending
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; iadr = 32'h4; dadr = 32'h8;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkOutput("rst_iack", {31'b0, iack}, 32'h0);
    checkOutput("rst_dack", {31'b0, dack}, 32'h0);
    checkOutput("rst_mreq", {31'b0, mreq}, 32'h0);
    checkOutput("rst_mwe", {31'b0, mwe}, 32'h0);
    checkOutput("rst_madr", madr, 32'h0);
    checkOutput("rst_mwdata", mwdata, 32'h0);
    checkOutput("rst_irdata", irdata, 32'h0);
    checkOutput("rst_istall", {31'b0, istall}, 32'h1);
    checkOutput("rst_dstall", {31'b0, dstall}, 32'h1);

    // Tie from reset: data, fetch, data, fetch
    @(posedge clk); #1; reset = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 20) ireq = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("tie_iack_c%0d", c), {31'b0, iack}, {31'b0, (c == 9 || c == 19)});
      checkOutput($sformatf("tie_dack_c%0d", c), {31'b0, dack}, {31'b0, (c == 4 || c == 14 || c == 24)});
      if (c == 4 || c == 14) checkOutput($sformatf("tie_drdata_c%0d", c), drdata, 32'h1000_0022);
      if (c == 9 || c == 19) checkOutput($sformatf("tie_irdata_c%0d", c), irdata, 32'h1000_0011);
    end
    @(posedge clk); #1; dreq = 1'b0;

    // Directed vectors from an idle arbiter
    for (int vi = 0; vi < 6; vi++) begin
      @(posedge clk); #1; applyStimulus(vecs[vi]);
      got = -1;
      for (int c = 0; c < 12 && got < 0; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        @(negedge clk);
        if (iack || dack) begin
          got = c;
          checkOutput($sformatf("vec%0d_iack", vi), {31'b0, iack}, {31'b0, !vecs[vi].is_data});
          checkOutput($sformatf("vec%0d_dack", vi), {31'b0, dack}, {31'b0, vecs[vi].is_data});
          checkOutput($sformatf("vec%0d_stall_ack", vi),
                      {31'b0, vecs[vi].is_data ? dstall : istall}, 32'h0);
          checkOutput($sformatf("vec%0d_rdata", vi),
                      vecs[vi].is_data ? drdata : irdata, vecs[vi].exp_rdata);
        end else begin
          checkOutput($sformatf("vec%0d_stall_c%0d", vi, c),
                      {31'b0, vecs[vi].is_data ? dstall : istall}, 32'h1);
          if (c == 1) begin
            checkOutput($sformatf("vec%0d_mreq", vi), {31'b0, mreq}, 32'h1);
            checkOutput($sformatf("vec%0d_mwe", vi), {31'b0, mwe}, {31'b0, vecs[vi].we});
            checkOutput($sformatf("vec%0d_madr", vi), madr, vecs[vi].adr);
            if (vecs[vi].we) checkOutput($sformatf("vec%0d_mwdata", vi), mwdata, vecs[vi].wdata);
          end
        end
      end
      checkOutput($sformatf("vec%0d_latency", vi), 32'(got), 32'(vecs[vi].exp_lat));
      @(posedge clk); #1; ireq = 1'b0; dreq = 1'b0;
    end

    // Data read whose address changes after capture
    @(posedge clk); #1; dreq = 1'b1; dwe = 1'b0; dadr = 32'h54;
    got = -1;
    for (int c = 0; c < 12 && got < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 1) dadr = 32'h8;
      @(negedge clk);
      if (c == 1) checkOutput("chg_madr_issue", madr, 32'h54);
      if (dack) begin
        got = c;
        checkOutput("chg_drdata", drdata, 32'h7);
        checkOutput("chg_madr_hold", madr, 32'h54);
      end
    end
    checkOutput("chg_latency", 32'(got), 32'd4);
    @(posedge clk); #1; dreq = 1'b0;

    // Reset during WAIT abandons the fetch; data then wins the post-reset tie
    @(posedge clk); #1; ireq = 1'b1; iadr = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; dreq = 1'b1; dwe = 1'b1; dadr = 32'h60; dwdata = 32'h55;
    #1;
    checkOutput("rstw_iack", {31'b0, iack}, 32'h0);
    checkOutput("rstw_dack", {31'b0, dack}, 32'h0);
    checkOutput("rstw_mreq", {31'b0, mreq}, 32'h0);
    checkOutput("rstw_irdata", irdata, 32'h0);
    checkOutput("rstw_madr", madr, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 3) begin dreq = 1'b0; dwe = 1'b0; end
      end
      @(negedge clk);
      checkOutput($sformatf("rstw_dack_c%0d", c), {31'b0, dack}, {31'b0, (c == 2)});
      checkOutput($sformatf("rstw_iack_c%0d", c), {31'b0, iack}, {31'b0, (c == 7)});
      if (c == 7) checkOutput("rstw_irdata_after", irdata, 32'h2002_0005);
    end
    @(posedge clk); #1; ireq = 1'b0;

    // Read latency for LAT=1 and LAT=4 instances
    @(posedge clk); #1; ireq_a = 1'b1; ireq_b = 1'b1;
    gota = -1; gotb = -1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (iack_a && gota < 0) begin
        gota = c;
        checkOutput("lat1_irdata", irdata_a, 32'h1111_0001);
      end
      if (iack_b && gotb < 0) begin
        gotb = c;
        checkOutput("lat4_irdata", irdata_b, 32'h4444_0004);
      end
    end
    checkOutput("lat1_latency", 32'(gota), 32'd3);
    checkOutput("lat4_latency", 32'(gotb), 32'd6);
    @(posedge clk); #1; ireq_a = 1'b0; ireq_b = 1'b0;

    // Randomized run against the transaction-level model
    @(posedge clk); #1; reset = 1'b1; ireq = 1'b0; dreq = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    m_busy = 0; m_last = 0; m_rd = '0; seen_i = 0; seen_d = 0;
    for (int n = 0; n < 600; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (ireq) begin
        if (seen_i) ireq = ($urandom_range(0, 1) == 0);
      end else begin
        ireq = ($urandom_range(0, 2) == 0);
      end
      if (dreq) begin
        if (seen_d) dreq = ($urandom_range(0, 1) == 0);
      end else begin
        dreq = ($urandom_range(0, 2) == 0);
      end
      iadr = randAdr(); dadr = randAdr(); dwe = 1'($urandom_range(0, 1)); dwdata = $urandom();

      @(negedge clk);
      exp_i = 0; exp_d = 0; exp_m = 0;
      if (m_busy) begin
        if (n == m_start + 1) exp_m = 1;
        if (n == m_ack_at) begin
          if (m_port) exp_d = 1; else exp_i = 1;
          if (m_we) shadow[m_adr[9:2]] = m_wd;
          else      m_rd = shadow[m_adr[9:2]];
          m_last = m_port;
        end
      end
      checkOutput("rnd_iack", {31'b0, iack}, {31'b0, exp_i});
      checkOutput("rnd_dack", {31'b0, dack}, {31'b0, exp_d});
      checkOutput("rnd_mreq", {31'b0, mreq}, {31'b0, exp_m});
      checkOutput("rnd_mwe", {31'b0, mwe}, {31'b0, exp_m && m_we});
      if (exp_m) checkOutput("rnd_madr", madr, m_adr);
      if (exp_m && m_we) checkOutput("rnd_mwdata", mwdata, m_wd);
      checkOutput("rnd_irdata", irdata, m_rd);
      checkOutput("rnd_drdata", drdata, m_rd);
      checkOutput("rnd_istall", {31'b0, istall}, {31'b0, ireq && !exp_i});
      checkOutput("rnd_dstall", {31'b0, dstall}, {31'b0, dreq && !exp_d});
      seen_i = iack; seen_d = dack;

      if (m_busy && n == m_ack_at) begin
        m_busy = 0;
      end else if (!m_busy && (ireq || dreq)) begin
        if (ireq && dreq) m_port = !m_last;
        else              m_port = dreq;
        m_we     = m_port ? dwe : 1'b0;
        m_adr    = m_port ? dadr : iadr;
        m_wd     = dwdata;
        m_start  = n;
        m_ack_at = n + (m_we ? 2 : LAT + 2);
        m_busy   = 1;
      end
    end
    @(posedge clk); #1;
    if (!(ireq && !seen_i) && !(dreq && !seen_d)) begin
      ireq = 1'b0; dreq = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
